// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR fault monitor: FSM state encoding
// and bit positions inside the latched alarm cause vector.
package tmr_pkg;

  typedef enum logic {
    MONITOR = 1'b0,
    ALARM   = 1'b1
  } tmr_state_e;

  localparam int CAUSE_R1     = 0;
  localparam int CAUSE_R2     = 1;
  localparam int CAUSE_R3     = 2;
  localparam int CAUSE_UNCORR = 3;
  localparam int CAUSE_W      = 4;

  localparam int PERS_W = 4;

endpackage

// File: rtl/tmr_replica_tracker.sv
// Per-replica bookkeeping: saturating fault counter, persistence run counter
// and the sticky failed flag that the run counter sets.
module tmr_replica_tracker
  import tmr_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PERSIST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_en,
  input  logic             mism,
  input  logic             uncorr,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             failed,
  output logic             fail_rise
);

  localparam logic [PERS_W-1:0] PERSIST_L = PERS_W'(PERSIST);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PERS_W-1:0] pers;
  logic              hit;

  // An uncorrectable sample says nothing about which replica is at fault,
  // so it never advances the persistence run.
  assign hit       = sample_en && mism && !uncorr;
  assign fail_rise = hit && !failed && (pers == PERSIST_L - 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt <= '0;
      pers      <= '0;
      failed    <= 1'b0;
    end else if (clear) begin
      fault_cnt <= '0;
      pers      <= '0;
      failed    <= 1'b0;
    end else if (sample_en) begin
      if (mism && fault_cnt != CNT_MAX) begin
        fault_cnt <= fault_cnt + 1'b1;
      end
      if (!mism) begin
        pers <= '0;
      end else if (hit && pers != PERSIST_L) begin
        pers <= pers + 4'd1;
      end
      if (fail_rise) begin
        failed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Watches three replicas against the voted value, tracks per-replica faults
// and raises a latched alarm until software acknowledges it.
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int CNT_W   = 16,
  parameter int PERSIST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] q_1,
  input  logic [WIDTH-1:0] q_2,
  input  logic [WIDTH-1:0] q_3,
  input  logic [WIDTH-1:0] voted_q,
  input  logic             ack,
  input  logic             clear,
  output logic [CNT_W-1:0] fault_cnt_1,
  output logic [CNT_W-1:0] fault_cnt_2,
  output logic [CNT_W-1:0] fault_cnt_3,
  output logic [2:0]       replica_failed,
  output logic [3:0]       cause,
  output logic             irq,
  output tmr_state_e       dbg_state
);

  // sample_en is a one-sided qualifier: no back-pressure, every cycle with
  // sample_en=1 consumes q_1..q_3/voted_q on that rising edge.
  logic [2:0]         mism;
  logic               uncorr;
  logic [2:0]         fail_rise;
  logic [CAUSE_W-1:0] new_ev;
  tmr_state_e         state;

  assign mism[0] = (q_1 != voted_q);
  assign mism[1] = (q_2 != voted_q);
  assign mism[2] = (q_3 != voted_q);
  assign uncorr  = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);

  tmr_replica_tracker #(.CNT_W(CNT_W), .PERSIST(PERSIST)) u_trk_1 (
    .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
    .mism(mism[0]), .uncorr(uncorr), .fault_cnt(fault_cnt_1),
    .failed(replica_failed[0]), .fail_rise(fail_rise[0])
  );

  tmr_replica_tracker #(.CNT_W(CNT_W), .PERSIST(PERSIST)) u_trk_2 (
    .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
    .mism(mism[1]), .uncorr(uncorr), .fault_cnt(fault_cnt_2),
    .failed(replica_failed[1]), .fail_rise(fail_rise[1])
  );

  tmr_replica_tracker #(.CNT_W(CNT_W), .PERSIST(PERSIST)) u_trk_3 (
    .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
    .mism(mism[2]), .uncorr(uncorr), .fault_cnt(fault_cnt_3),
    .failed(replica_failed[2]), .fail_rise(fail_rise[2])
  );

  always_comb begin
    new_ev               = '0;
    new_ev[CAUSE_R1]     = fail_rise[0];
    new_ev[CAUSE_R2]     = fail_rise[1];
    new_ev[CAUSE_R3]     = fail_rise[2];
    new_ev[CAUSE_UNCORR] = sample_en && uncorr;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MONITOR;
      cause <= '0;
      irq   <= 1'b0;
    end else if (clear) begin
      state <= MONITOR;
      cause <= '0;
      irq   <= 1'b0;
    end else begin
      cause <= cause | new_ev;
      case (state)
        MONITOR: begin
          if (|new_ev) begin
            state <= ALARM;
            irq   <= 1'b1;
          end
        end
        ALARM: begin
          if (ack && !(|new_ev)) begin
            state <= MONITOR;
            irq   <= 1'b0;
          end
        end
        default: begin
          state <= MONITOR;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tmr_fault_monitor.md
TMR_FAULT_MONITOR -- requirements
Module: tmr_fault_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 128, replica/voted value width.
REQ-002 SHALL have parameter CNT_W, default 16, width of each per-replica fault counter.
REQ-003 SHALL have parameter PERSIST, default 4, range 1..15, consecutive mismatching samples that declare a replica failed.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port sample_en, input, 1, qualifies the current inputs as a valid sample.
REQ-007 SHALL have ports q_1, q_2, q_3, input, WIDTH each, the three replica register values.
REQ-008 SHALL have port voted_q, input, WIDTH, the majority-voted value.
REQ-009 SHALL have port ack, input, 1, a single-cycle pulse that acknowledges the alarm.
REQ-010 SHALL have port clear, input, 1, a single-cycle pulse that clears counters, sticky flags and cause.
REQ-011 SHALL have ports fault_cnt_1, fault_cnt_2, fault_cnt_3, output, CNT_W each, counts of sampled mismatches.
REQ-012 SHALL have port replica_failed, output, 3, sticky per-replica failure flags, where bit i-1 corresponds to replica i.
REQ-013 SHALL have port cause, output, 4, latched alarm cause: bits [2:0] are failed replicas, bit [3] is uncorrectable.
REQ-014 SHALL have port irq, output, 1, alarm request, high while the FSM is in ALARM.

Function
REQ-015 SHALL compute, per sample, mism_i = (q_i != voted_q) and uncorr = (q_1!=q_2 && q_1!=q_3 && q_2!=q_3).
REQ-016 SHALL use only registered outputs, each updating on the edge that consumes the sample; irq rises 1 cycle after the triggering sample.
REQ-017 SHALL increment fault_cnt_i on each sample with mism_i=1, saturating at 2^CNT_W-1 with no wrap.
REQ-018 SHALL keep a per-replica persistence counter (4 bits): +1 on a sample with mism_i, reset to 0 on a sample without mism_i, held when sample_en=0.
REQ-019 SHALL set replica_failed[i-1] on the edge where persistence_i reaches PERSIST; the flag is sticky until clear or rst, and the persistence counter saturates at PERSIST.
REQ-020 SHALL implement FSM states MONITOR and ALARM; reset state is MONITOR.
REQ-021 SHALL take MONITOR->ALARM on a sampled uncorr, or on any replica_failed bit newly rising; irq=1 in ALARM.
REQ-022 SHALL OR new events into cause, in MONITOR and in ALARM alike; cause is cleared only by clear or rst.
REQ-023 SHALL take ALARM->MONITOR on ack with no new event in the same cycle; ack together with a new event keeps ALARM and ORs in the cause.
REQ-024 SHALL ignore ack in MONITOR.
REQ-025 SHALL on clear zero the fault counters, persistence counters, replica_failed and cause, and force MONITOR; clear takes priority over a simultaneous sample, event or ack.
REQ-026 SHALL NOT increment any counter or flag an event when sample_en=0.
REQ-027 SHALL NOT increment persistence or set replica_failed on an uncorr sample; fault counters still count each mism_i.

Reset
REQ-028 SHALL on rst drive fault_cnt_1..3=0, replica_failed=3'b000, cause=4'b0000, irq=0, all persistence counters to 0, and state MONITOR, immediately and asynchronously.
REQ-029 SHALL abandon an alarm or persistence run in progress on rst mid-operation, with no residual state.

Structure
REQ-030 SHALL place the FSM state enum (MONITOR, ALARM) and the cause bit-index constants in shared package tmr_pkg.
REQ-031 SHALL instantiate three copies of one sub-module, tmr_replica_tracker, which holds the fault counter, the persistence counter and the sticky flag for one replica.

Verification
REQ-032 SHALL test: rst, then q_1=q_2=q_3=voted_q=5 sampled for 10 cycles -> all counters 0, irq=0.
REQ-033 SHALL test: q_2=9, others=5, voted_q=5, sampled 4 consecutive cycles -> fault_cnt_2=4, replica_failed=3'b010, cause=4'b0010, irq=1 on the cycle after the 4th sample.
REQ-034 SHALL test: q_3 mismatching for 3 samples, then matching for 1, then mismatching for 3 -> fault_cnt_3=6, replica_failed=0, irq=0.
REQ-035 SHALL test: q_1=1, q_2=2, q_3=4, voted_q=0, one sample -> cause[3]=1, irq=1, all fault counters=1, replica_failed=0.
REQ-036 SHALL test: in ALARM, ack pulse -> irq=0 next cycle, cause held; ack coinciding with a new uncorr sample -> irq stays 1.
REQ-037 SHALL test: with CNT_W=4, 20 mismatching samples on replica 1 -> fault_cnt_1=15 (saturated); a clear pulse -> all outputs 0 next cycle.
